// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: arbitrates ID/EX/MEM
// stall requests and MEM flushes, and sequences multi-cycle EX operations.
module pipe_stall_ctrl #(
   parameter int EX_CYCLES   = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stallreq_id,
   input  logic        ex_start,
   input  logic        ex_cancel,
   input  logic        mem_busy,
   input  logic        flush_req,
   input  logic [31:0] new_pc_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        ex_done,
   output logic        ex_busy,
   output logic        timeout_o,
   output logic [1:0]  state_o
);

   localparam logic [1:0] S_RUN     = 2'b00;
   localparam logic [1:0] S_EX_WAIT = 2'b01;
   localparam logic [1:0] S_EX_HOLD = 2'b10;

   localparam logic [5:0] STALL_ID  = 6'b000111;
   localparam logic [5:0] STALL_EX  = 6'b001111;
   localparam logic [5:0] STALL_MEM = 6'b011111;

   localparam int CW = $clog2(EX_CYCLES);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [WW-1:0] wcnt;
   logic          flush_pend;
   logic [31:0]   pend_pc;

   logic          flush;
   logic          abort;
   logic          ex_stall;
   logic          done;
   logic          wd_hit;
   logic [5:0]    stall;

   assign flush  = (flush_pend | flush_req) & ~mem_busy;
   assign abort  = ex_cancel | flush;
   assign wd_hit = mem_busy && (wcnt == WW'(MEM_TIMEOUT - 1));

   // NOTE: every signal written here gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done      = 1'b0;
      ex_stall  = 1'b0;
      case (state)
         S_RUN: begin
            if (ex_start && !flush) begin
               ex_stall  = 1'b1;
               cnt_nxt   = CW'(EX_CYCLES - 1);
               state_nxt = S_EX_WAIT;
            end
         end
         S_EX_WAIT: begin
            if (abort) begin
               state_nxt = S_RUN;
               cnt_nxt   = '0;
            end else if (cnt == '0) begin
               // Count expired: finish now, or park until the bus frees up.
               if (mem_busy) begin
                  state_nxt = S_EX_HOLD;
               end else begin
                  done      = 1'b1;
                  state_nxt = S_RUN;
               end
            end else begin
               ex_stall = 1'b1;
               cnt_nxt  = cnt - CW'(1);
            end
         end
         S_EX_HOLD: begin
            if (abort) begin
               state_nxt = S_RUN;
               cnt_nxt   = '0;
            end else if (!mem_busy) begin
               done      = 1'b1;
               state_nxt = S_RUN;
            end
         end
         default: begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      stall = 6'b000000;
      if (flush)            stall = 6'b000000;
      else if (mem_busy)    stall = STALL_MEM;
      else if (ex_stall)    stall = STALL_EX;
      else if (stallreq_id) stall = STALL_ID;
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_RUN;
         cnt        <= '0;
         wcnt       <= '0;
         flush_pend <= 1'b0;
         pend_pc    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (!mem_busy || wd_hit) wcnt <= '0;
         else                     wcnt <= wcnt + WW'(1);
         // A flush arriving during a bus wait is held; later requests cannot displace it.
         if (flush) begin
            flush_pend <= 1'b0;
         end else if (flush_req && mem_busy && !flush_pend) begin
            flush_pend <= 1'b1;
            pend_pc    <= new_pc_i;
         end
      end
   end

   // Outputs are forced quiet while reset is asserted, including the combinational ones.
   assign stall_o   = resetn ? stall : 6'b000000;
   assign flush_o   = resetn & flush;
   assign new_pc_o  = resetn ? (flush_pend ? pend_pc : new_pc_i) : 32'h0;
   assign ex_done   = resetn & done;
   assign ex_busy   = resetn & (state != S_RUN);
   assign timeout_o = resetn & wd_hit;
   assign state_o   = resetn ? state : S_RUN;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scenario bench for pipe_stall_ctrl: per-cycle expectations are queued when
// stimulus is driven and compared mid-cycle against the DUT outputs.
module tb_pipe_stall_ctrl;

   typedef struct packed {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        done;
      logic        busy;
      logic        tmo;
      logic [1:0]  st;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        stallreq_id, ex_start, ex_cancel, mem_busy, flush_req;
   logic [31:0] new_pc_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        ex_done, ex_busy, timeout_o;
   logic [1:0]  state_o;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   pipe_stall_ctrl #(.EX_CYCLES(4), .MEM_TIMEOUT(3)) dut (
      .clk(clk), .resetn(resetn), .stallreq_id(stallreq_id), .ex_start(ex_start),
      .ex_cancel(ex_cancel), .mem_busy(mem_busy), .flush_req(flush_req),
      .new_pc_i(new_pc_i), .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
      .ex_done(ex_done), .ex_busy(ex_busy), .timeout_o(timeout_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, compare at the falling edge.
   task automatic cyc(input logic rst, input logic id, input logic exs, input logic exc,
                      input logic mb, input logic fr, input logic [31:0] pc,
                      input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                      input logic e_done, input logic e_busy, input logic e_tmo,
                      input logic [1:0] e_st);
      exp_t e;
      resetn = rst; stallreq_id = id; ex_start = exs; ex_cancel = exc;
      mem_busy = mb; flush_req = fr; new_pc_i = pc;
      sb.push_back('{e_stall, e_flush, e_pc, e_done, e_busy, e_tmo, e_st});
      @(negedge clk);
      e = sb.pop_front();
      check("stall_o", 32'(stall_o), 32'(e.stall));
      check("flush_o", 32'(flush_o), 32'(e.flush));
      if (e.flush) check("new_pc_o", new_pc_o, e.pc);
      check("ex_done", 32'(ex_done), 32'(e.done));
      check("ex_busy", 32'(ex_busy), 32'(e.busy));
      check("timeout_o", 32'(timeout_o), 32'(e.tmo));
      check("state_o", 32'(state_o), 32'(e.st));
      @(posedge clk);
      #1;
   endtask

   // Reset with noisy inputs: every output must still read zero.
   task automatic do_reset();
      for (int i = 0; i < 2; i++)
         cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF,
             6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   initial begin
      logic [5:0] es;
      resetn = 1'b0; stallreq_id = 1'b0; ex_start = 1'b0; ex_cancel = 1'b0;
      mem_busy = 1'b0; flush_req = 1'b0; new_pc_i = 32'h0;
      @(posedge clk);
      #1;

      // Basic multi-cycle op with ID requests before, during and at completion.
      do_reset();
      for (int c = 0; c < 17; c++) begin
         es = (c == 2 || c == 14) ? 6'b000111 : (c >= 10 && c <= 13) ? 6'b001111 : 6'b000000;
         cyc(1'b1, c == 2 || c == 12 || c == 14, c == 10, 1'b0, 1'b0, 1'b0, 32'h0,
             es, 1'b0, 32'h0, c == 14, c >= 11 && c <= 14, 1'b0,
             (c >= 11 && c <= 14) ? 2'b01 : 2'b00);
      end

      // Multi-cycle op stretched by a MEM wait into EX_HOLD; watchdog fires at 14.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         es = (c >= 12 && c <= 16) ? 6'b011111 : (c == 10 || c == 11) ? 6'b001111 : 6'b000000;
         cyc(1'b1, 1'b0, c == 10, 1'b0, c >= 12 && c <= 16, 1'b0, 32'h0,
             es, 1'b0, 32'h0, c == 17, c >= 11 && c <= 17, c == 14,
             (c >= 11 && c <= 14) ? 2'b01 : (c >= 15 && c <= 17) ? 2'b10 : 2'b00);
      end

      // Flush held across a bus wait; the second request must not replace the PC.
      do_reset();
      for (int c = 0; c < 11; c++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, c >= 5 && c <= 7, c == 5 || c == 7,
             (c == 5) ? 32'hBFC0_0380 : (c == 7) ? 32'h0000_1234 : 32'h0000_5555,
             (c >= 5 && c <= 7) ? 6'b011111 : 6'b000000, c == 8, 32'hBFC0_0380,
             1'b0, 1'b0, c == 7, 2'b00);
      end

      // Flush aborts an EX op; a new start right after runs the full count.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         es = ((c >= 10 && c <= 11) || (c >= 13 && c <= 16)) ? 6'b001111 : 6'b000000;
         cyc(1'b1, 1'b0, c == 10 || c == 13, 1'b0, 1'b0, c == 12, 32'h8000_0000,
             es, c == 12, 32'h8000_0000, c == 17,
             (c >= 11 && c <= 12) || (c >= 14 && c <= 17), 1'b0,
             ((c >= 11 && c <= 12) || (c >= 14 && c <= 17)) ? 2'b01 : 2'b00);
      end

      // Watchdog with MEM_TIMEOUT=3 over a 7-cycle bus wait.
      do_reset();
      for (int c = 0; c < 9; c++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, c <= 6, 1'b0, 32'h0,
             (c <= 6) ? 6'b011111 : 6'b000000, 1'b0, 32'h0,
             1'b0, 1'b0, c == 2 || c == 5, 2'b00);
      end

      // Reset in the middle of EX_WAIT: quiet outputs and no late ex_done.
      do_reset();
      for (int c = 0; c < 13; c++) begin
         cyc(c != 5, 1'b0, c == 3, 1'b0, 1'b0, 1'b0, 32'h0,
             (c == 3 || c == 4) ? 6'b001111 : 6'b000000, 1'b0, 32'h0,
             1'b0, c == 4, 1'b0, (c == 4) ? 2'b01 : 2'b00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
